// File: rtl/serial_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_bus_arbiter
// Purpose  : Two-initiator arbiter and sequencer for the shared serial bus.
//            Tracks the serial address phase and data phase of each
//            transaction and releases the bus when it completes. Supports one
//            parked split transaction that is re-granted for its reply.
// Options  : ARB_ROUND_ROBIN_EN - round-robin on simultaneous requests
//            (fixed priority to initiator 1 when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module serial_bus_arbiter #(
  parameter int ADDR_BITS      = 16,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_1,
  input  logic req_2,
  input  logic bus_data_in_valid,
  input  logic bus_mode,
  input  logic split_defer,
  input  logic split_resume,
  output logic gnt_1,
  output logic gnt_2,
  output logic msel,
  output logic split,
  output logic split_pending,
  output logic bus_busy,
  output logic arb_timeout
);

  localparam int c_CNT_MAX = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
  localparam int c_WD_W    = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_BITS - 1);
  localparam logic [c_WD_W-1:0]  c_WD_LAST   = c_WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ADDR       = 2'd1,
    S_DATA       = 2'd2,
    S_SPLIT_DATA = 2'd3
  } state_t;

  // Owner encoding: 0 = initiator 1, 1 = initiator 2 (matches msel).
  state_t               r_state;
  logic                 r_owner;
  logic                 r_last_owner;
  logic                 r_split_owner;
  logic                 r_resume_latch;
  logic [c_CNT_W-1:0]   r_bit_cnt;
  logic [c_WD_W-1:0]    r_wd_cnt;

  logic w_addr_bit;
  logic w_data_bit;
  logic w_owner_req;
  logic w_wd_expire;
  logic w_resume_now;
  logic w_pref;
  logic w_winner;

  assign w_addr_bit   = bus_data_in_valid & ~bus_mode;
  assign w_data_bit   = bus_data_in_valid & bus_mode;
  assign w_owner_req  = r_owner ? req_2 : req_1;
  assign w_wd_expire  = ~bus_data_in_valid & (r_wd_cnt == c_WD_LAST);
  assign w_resume_now = r_resume_latch | (split_resume & split_pending);

`ifdef ARB_ROUND_ROBIN_EN
  // Simultaneous requests go to whoever did not own the bus last.
  assign w_pref = ~r_last_owner;
`else
  // Fixed priority: initiator 1 always wins; last_owner is tracked but ignored.
  assign w_pref = r_last_owner & 1'b0;
`endif

  // A lone requester wins outright; a tie falls back to the preference.
  assign w_winner = (req_1 & req_2) ? w_pref : req_2;

  // Arbitration FSM with registered grant, select and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_owner        <= 1'b0;
      r_last_owner   <= 1'b1;
      r_split_owner  <= 1'b0;
      r_resume_latch <= 1'b0;
      r_bit_cnt      <= '0;
      r_wd_cnt       <= '0;
      gnt_1          <= 1'b0;
      gnt_2          <= 1'b0;
      msel           <= 1'b0;
      split          <= 1'b0;
      split_pending  <= 1'b0;
      bus_busy       <= 1'b0;
      arb_timeout    <= 1'b0;
    end else begin
      arb_timeout <= 1'b0;
      r_wd_cnt    <= (bus_data_in_valid || r_state == S_IDLE) ? '0 : r_wd_cnt + 1'b1;
      // A resume that arrives while the bus is busy is held until IDLE.
      if (split_resume && split_pending && r_state != S_IDLE) begin
        r_resume_latch <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= '0;
          if (w_resume_now) begin
            r_state   <= S_SPLIT_DATA;
            r_owner   <= r_split_owner;
            gnt_1     <= ~r_split_owner;
            gnt_2     <= r_split_owner;
            msel      <= r_split_owner;
            split     <= 1'b1;
            bus_busy  <= 1'b1;
          end else if (req_1 || req_2) begin
            r_state      <= S_ADDR;
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            gnt_1        <= ~w_winner;
            gnt_2        <= w_winner;
            msel         <= w_winner;
            bus_busy     <= 1'b1;
          end
        end

        S_ADDR: begin
          if (w_addr_bit && r_bit_cnt == c_ADDR_LAST) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
            r_wd_cnt  <= '0;
          end else if (!w_owner_req || w_wd_expire) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_wd_cnt    <= '0;
            gnt_1       <= 1'b0;
            gnt_2       <= 1'b0;
            bus_busy    <= 1'b0;
            arb_timeout <= w_owner_req;
          end else if (w_addr_bit) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_data_bit && r_bit_cnt == c_DATA_LAST) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_wd_cnt  <= '0;
            gnt_1     <= 1'b0;
            gnt_2     <= 1'b0;
            bus_busy  <= 1'b0;
          end else if (split_defer && r_bit_cnt == '0 && !split_pending) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_wd_cnt      <= '0;
            gnt_1         <= 1'b0;
            gnt_2         <= 1'b0;
            bus_busy      <= 1'b0;
            split_pending <= 1'b1;
            r_split_owner <= r_owner;
          end else if (!w_owner_req || w_wd_expire) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_wd_cnt    <= '0;
            gnt_1       <= 1'b0;
            gnt_2       <= 1'b0;
            bus_busy    <= 1'b0;
            arb_timeout <= w_owner_req;
          end else if (w_data_bit) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

        S_SPLIT_DATA: begin
          if ((w_data_bit && r_bit_cnt == c_DATA_LAST) || w_wd_expire) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= '0;
            r_wd_cnt       <= '0;
            gnt_1          <= 1'b0;
            gnt_2          <= 1'b0;
            split          <= 1'b0;
            bus_busy       <= 1'b0;
            split_pending  <= 1'b0;
            r_resume_latch <= 1'b0;
            arb_timeout    <= ~(w_data_bit && r_bit_cnt == c_DATA_LAST);
          end else if (w_data_bit) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bus_arbiter
// Purpose  : Directed self-checking bench for serial_bus_arbiter. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bus_arbiter;

  logic clk;
  logic rst_n;
  logic req_1;
  logic req_2;
  logic bus_data_in_valid;
  logic bus_mode;
  logic split_defer;
  logic split_resume;
  logic gnt_1;
  logic gnt_2;
  logic msel;
  logic split;
  logic split_pending;
  logic bus_busy;
  logic arb_timeout;

  int n_cmp;
  int n_err;

  logic [6:0] outs;
  assign outs = {gnt_1, gnt_2, msel, split, split_pending, bus_busy, arb_timeout};

  serial_bus_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_1             (req_1),
    .req_2             (req_2),
    .bus_data_in_valid (bus_data_in_valid),
    .bus_mode          (bus_mode),
    .split_defer       (split_defer),
    .split_resume      (split_resume),
    .gnt_1             (gnt_1),
    .gnt_2             (gnt_2),
    .msel              (msel),
    .split             (split),
    .split_pending     (split_pending),
    .bus_busy          (bus_busy),
    .arb_timeout       (arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: run did not finish (actual running, required finished)");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req_1 = 1'b0;
    req_2 = 1'b0;
    bus_data_in_valid = 1'b0;
    bus_mode = 1'b0;
    split_defer = 1'b0;
    split_resume = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive n consecutive valid bits in the given mode, one per clock.
  task automatic send_bits(input int n, input logic mode);
    for (int i = 0; i < n; i++) begin
      bus_data_in_valid = 1'b1;
      bus_mode = mode;
      @(negedge clk);
    end
    bus_data_in_valid = 1'b0;
    bus_mode = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (outs !== 7'b0000000) begin
      n_err++;
      $display("FAIL reset_outputs: actual %b required %b", outs, 7'b0000000);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_1 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== 7'b1000010) begin
      n_err++;
      $display("FAIL single_grant: actual %b required %b", outs, 7'b1000010);
    end
    // Three data-mode bits inside the address phase must not count.
    send_bits(8, 1'b0);
    send_bits(3, 1'b1);
    send_bits(8, 1'b0);
    n_cmp++;
    if (outs !== 7'b1000010) begin
      n_err++;
      $display("FAIL single_after_addr: actual %b required %b", outs, 7'b1000010);
    end
    send_bits(7, 1'b1);
    n_cmp++;
    if (outs !== 7'b1000010) begin
      n_err++;
      $display("FAIL single_before_last_bit: actual %b required %b", outs, 7'b1000010);
    end
    send_bits(1, 1'b1);
    n_cmp++;
    if (outs !== 7'b0000000) begin
      n_err++;
      $display("FAIL single_release: actual %b required %b", outs, 7'b0000000);
    end
    req_1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== 7'b0000000) begin
      n_err++;
      $display("FAIL single_idle_after: actual %b required %b", outs, 7'b0000000);
    end
  endtask

  task automatic test_arbitration();
    logic [6:0] exp_second;
    logic [6:0] exp_abort;
`ifdef ARB_ROUND_ROBIN_EN
    exp_second = 7'b0110010;
    exp_abort  = 7'b0010000;
`else
    exp_second = 7'b1000010;
    exp_abort  = 7'b0000000;
`endif
    apply_reset();
    req_1 = 1'b1;
    req_2 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== 7'b1000010) begin
      n_err++;
      $display("FAIL arb_first_grant: actual %b required %b", outs, 7'b1000010);
    end
    send_bits(16, 1'b0);
    send_bits(8, 1'b1);
    n_cmp++;
    if (outs !== 7'b0000000) begin
      n_err++;
      $display("FAIL arb_idle_gap: actual %b required %b", outs, 7'b0000000);
    end
    @(negedge clk);
    n_cmp++;
    if (outs !== exp_second) begin
      n_err++;
      $display("FAIL arb_second_grant: actual %b required %b", outs, exp_second);
    end
    // A defer after the first data bit is not a split candidate.
    send_bits(16, 1'b0);
    send_bits(1, 1'b1);
    split_defer = 1'b1;
    send_bits(1, 1'b1);
    split_defer = 1'b0;
    n_cmp++;
    if (outs !== exp_second) begin
      n_err++;
      $display("FAIL arb_late_defer_ignored: actual %b required %b", outs, exp_second);
    end
    // Owner withdraws mid-data: silent abort, msel keeps its value.
    req_1 = 1'b0;
    req_2 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== exp_abort) begin
      n_err++;
      $display("FAIL arb_req_drop_abort: actual %b required %b", outs, exp_abort);
    end
  endtask

  task automatic test_split();
    apply_reset();
    req_1 = 1'b1;
    @(negedge clk);
    // Address 0x8000: sixteen address-phase bits.
    send_bits(16, 1'b0);
    split_defer = 1'b1;
    @(negedge clk);
    split_defer = 1'b0;
    req_1 = 1'b0;
    n_cmp++;
    if (outs !== 7'b0000100) begin
      n_err++;
      $display("FAIL split_parked: actual %b required %b", outs, 7'b0000100);
    end
    req_2 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== 7'b0110110) begin
      n_err++;
      $display("FAIL split_other_grant: actual %b required %b", outs, 7'b0110110);
    end
    send_bits(8, 1'b0);
    split_resume = 1'b1;
    send_bits(1, 1'b0);
    split_resume = 1'b0;
    send_bits(7, 1'b0);
    n_cmp++;
    if (outs !== 7'b0110110) begin
      n_err++;
      $display("FAIL split_resume_latched_busy: actual %b required %b", outs, 7'b0110110);
    end
    send_bits(8, 1'b1);
    req_2 = 1'b0;
    n_cmp++;
    if (outs !== 7'b0010100) begin
      n_err++;
      $display("FAIL split_other_done: actual %b required %b", outs, 7'b0010100);
    end
    @(negedge clk);
    n_cmp++;
    if (outs !== 7'b1001110) begin
      n_err++;
      $display("FAIL split_reply_grant: actual %b required %b", outs, 7'b1001110);
    end
    send_bits(7, 1'b1);
    n_cmp++;
    if (outs !== 7'b1001110) begin
      n_err++;
      $display("FAIL split_reply_mid: actual %b required %b", outs, 7'b1001110);
    end
    send_bits(1, 1'b1);
    n_cmp++;
    if (outs !== 7'b0000000) begin
      n_err++;
      $display("FAIL split_reply_done: actual %b required %b", outs, 7'b0000000);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req_1 = 1'b1;
    @(negedge clk);
    repeat (63) @(negedge clk);
    n_cmp++;
    if (outs !== 7'b1000010) begin
      n_err++;
      $display("FAIL timeout_not_early: actual %b required %b", outs, 7'b1000010);
    end
    @(negedge clk);
    n_cmp++;
    if (outs !== 7'b0000001) begin
      n_err++;
      $display("FAIL timeout_pulse: actual %b required %b", outs, 7'b0000001);
    end
    req_1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== 7'b0000000) begin
      n_err++;
      $display("FAIL timeout_single_pulse: actual %b required %b", outs, 7'b0000000);
    end
  endtask

  task automatic test_reset_in_split();
    apply_reset();
    req_1 = 1'b1;
    @(negedge clk);
    send_bits(16, 1'b0);
    split_defer = 1'b1;
    @(negedge clk);
    split_defer = 1'b0;
    req_1 = 1'b0;
    split_resume = 1'b1;
    @(negedge clk);
    split_resume = 1'b0;
    n_cmp++;
    if (outs !== 7'b1001110) begin
      n_err++;
      $display("FAIL rst_split_entry: actual %b required %b", outs, 7'b1001110);
    end
    send_bits(3, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== 7'b0000000) begin
      n_err++;
      $display("FAIL rst_split_cleared: actual %b required %b", outs, 7'b0000000);
    end
    rst_n = 1'b1;
    split_resume = 1'b1;
    @(negedge clk);
    split_resume = 1'b0;
    n_cmp++;
    if (outs !== 7'b0000000) begin
      n_err++;
      $display("FAIL rst_resume_ignored: actual %b required %b", outs, 7'b0000000);
    end
    @(negedge clk);
    n_cmp++;
    if (outs !== 7'b0000000) begin
      n_err++;
      $display("FAIL rst_resume_not_latched: actual %b required %b", outs, 7'b0000000);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_arbitration();
    test_split();
    test_timeout();
    test_reset_in_split();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
